// File: rtl/mfp_reset_pkg.sv
// -----------------------------------------------------------------------------
// mfp_reset_pkg
// Shared types and constants for the mfp reset sequencer.
//   state_e         : sequencer states (WAIT_LOCK=0, PERIPH=1, RUN=2)
//   RST_CAUSE_*     : 2-bit codes reported on reset_cause
//   max_int()       : elaboration-time helper for sizing the shared counter
// -----------------------------------------------------------------------------
package mfp_reset_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_PERIPH    = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
  localparam logic [1:0] RST_CAUSE_LOCK = 2'b01;
  localparam logic [1:0] RST_CAUSE_BTN  = 2'b10;
  localparam logic [1:0] RST_CAUSE_SOFT = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mfp_sync_ff.sv
// -----------------------------------------------------------------------------
// mfp_sync_ff
// Multi-flop synchronizer for an asynchronous single-bit input.
// Parameters:
//   SYNC_STAGES : number of flops in the chain (>= 2)
//   RESET_VAL   : value loaded into every stage while resetn is low
// Ports:
//   clk    in  : destination clock
//   resetn in  : synchronous active-low reset
//   i_d    in  : asynchronous input
//   o_q    out : synchronized output (last stage of the chain)
// -----------------------------------------------------------------------------
module mfp_sync_ff #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // NOTE: every stage is reset, not just the output flop, so no stale sample
  // can ripple out of the chain in the cycles right after reset is released.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/mfp_reset_sequencer.sv
// -----------------------------------------------------------------------------
// mfp_reset_sequencer
// Ordered reset release for mfp_system: waits for a stable PLL lock, releases
// the peripheral/bus reset, then releases the core reset CPU_DELAY cycles
// later. Lock loss, the board button or a soft request restarts the sequence;
// the cause of the latest restart is held on reset_cause.
//
// Optional feature macro: MFP_RESET_DEBOUNCE_EN
//   defined   : synchronized button is debounced over DEBOUNCE_CYCLES cycles
//   undefined : synchronized button is used directly
//
// Parameters:
//   LOCK_STABLE_CYCLES : cycles locked_s must stay high before release (>= 2)
//   CPU_DELAY          : cycles from peripheral release to core release (>= 1)
//   SYNC_STAGES        : synchronizer depth for locked / btn_resetn (>= 2)
//   DEBOUNCE_CYCLES    : button stable time (macro builds only)
// Ports:
//   clk            in  : clk_cpu from the clock stage
//   resetn         in  : synchronous active-low reset
//   locked         in  : asynchronous lock flag from the clock stage
//   btn_resetn     in  : asynchronous active-low board reset button
//   soft_reset_req in  : one-cycle restart request, synchronous to clk
//   periph_resetn  out : peripheral/bus reset, active-low
//   cpu_reset      out : core reset (SI_Reset), active-high
//   run            out : high only in RUN
//   reset_cause    out : 00 POR, 01 lock loss, 10 button, 11 soft
// -----------------------------------------------------------------------------
module mfp_reset_sequencer
  import mfp_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CPU_DELAY          = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 65536
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       locked,
  input  logic       btn_resetn,
  input  logic       soft_reset_req,
  output logic       periph_resetn,
  output logic       cpu_reset,
  output logic       run,
  output logic [1:0] reset_cause
);

  // One counter serves both timed states; it is cleared on every state change
  // and compared for equality, so it only needs to reach max-1.
  localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, CPU_DELAY);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);

  logic w_locked_s;
  logic w_btn_sync;
  logic w_btn_s;
  logic w_restart;
  logic [1:0] w_restart_cause;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_periph_resetn;
  logic             r_cpu_reset;
  logic             r_run;
  logic [1:0]       r_cause;

  mfp_sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_locked (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (locked),
    .o_q    (w_locked_s)
  );

  mfp_sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_btn (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (btn_resetn),
    .o_q    (w_btn_sync)
  );

`ifdef MFP_RESET_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_db;

  // The filtered level follows the synchronized button only after it has
  // disagreed with the filtered level for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
    end else if (w_btn_sync == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_btn_db <= w_btn_sync;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_btn_s = r_btn_db;
`else
  assign w_btn_s = w_btn_sync;
`endif

  // Restart sources, highest priority first: lock loss, button, soft.
  // NOTE: the default assignment at the top of the block guarantees every
  // path assigns the output, so no latch is inferred.
  always_comb begin
    w_restart_cause = RST_CAUSE_SOFT;
    if (!w_locked_s) begin
      w_restart_cause = RST_CAUSE_LOCK;
    end else if (!w_btn_s) begin
      w_restart_cause = RST_CAUSE_BTN;
    end
  end

  assign w_restart = !w_locked_s || !w_btn_s || soft_reset_req;

  // Outputs are loaded together with the next state so they move on the
  // transition edge itself.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state         <= ST_WAIT_LOCK;
      r_cnt           <= '0;
      r_cause         <= RST_CAUSE_POR;
      r_periph_resetn <= 1'b0;
      r_cpu_reset     <= 1'b1;
      r_run           <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          // Any restart source here only restarts the stability count.
          if (w_restart) begin
            r_cnt <= '0;
          end else if (r_cnt == LOCK_LAST) begin
            r_state         <= ST_PERIPH;
            r_cnt           <= '0;
            r_periph_resetn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_PERIPH, ST_RUN: begin
          if (w_restart) begin
            r_state         <= ST_WAIT_LOCK;
            r_cnt           <= '0;
            r_cause         <= w_restart_cause;
            r_periph_resetn <= 1'b0;
            r_cpu_reset     <= 1'b1;
            r_run           <= 1'b0;
          end else if (r_state == ST_PERIPH) begin
            if (r_cnt == CPU_LAST) begin
              r_state     <= ST_RUN;
              r_cnt       <= '0;
              r_cpu_reset <= 1'b0;
              r_run       <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          // Unused encoding: fall back to the safe, fully-reset state.
          r_state         <= ST_WAIT_LOCK;
          r_cnt           <= '0;
          r_periph_resetn <= 1'b0;
          r_cpu_reset     <= 1'b1;
          r_run           <= 1'b0;
        end
      endcase
    end
  end

  assign periph_resetn = r_periph_resetn;
  assign cpu_reset     = r_cpu_reset;
  assign run           = r_run;
  assign reset_cause   = r_cause;

endmodule

// File: doc/mfp_reset_sequencer.md
# mfp_reset_sequencer

Reset sequencer that sits directly downstream of the clock generator/bypass stage in `mfp_system`. It consumes the `locked` flag and produces ordered resets: peripherals are released first, then the MIPS core. Any lock loss, button press or software/debug request restarts the sequence. The cause of the most recent reset is latched for software.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive cycles `locked_s` must stay high before peripherals are released; minimum 2.
- `CPU_DELAY`, default 16: cycles between the peripheral release and the core release; minimum 1.
- `SYNC_STAGES`, default 2: flop stages in each input synchronizer; minimum 2.
- `DEBOUNCE_CYCLES`, default 65536: button stable time; used only with the macro.
- `clk` in 1: the single clock, `clk_cpu` from the clock stage.
- `resetn` in 1: reset, synchronous, active-low.
- `locked` in 1: clock-stage lock flag; asynchronous, so it is synchronized.
- `btn_resetn` in 1: board reset button, active-low, asynchronous; synchronized.
- `soft_reset_req` in 1: single-cycle pulse from the debug/bus side, synchronous to `clk`.
- `periph_resetn` out 1: peripheral/bus reset, active-low.
- `cpu_reset` out 1: core reset (`SI_Reset`), active-high.
- `run` out 1: high only in RUN.
- `reset_cause` out 2: cause of the last sequence. 00 power-on, 01 lock loss, 10 button, 11 soft.

## Operation
- Clock and reset are fixed: one clock, `clk`; `resetn` is synchronous and active-low.
- States: WAIT_LOCK, PERIPH, RUN. `resetn`=0 forces WAIT_LOCK, `reset_cause`=00, counter=0, and clears the synchronizers.
- WAIT_LOCK:
  - Counter increments on each edge with `locked_s`=1 and clears when `locked_s`=0.
  - On the edge where `locked_s`=1 and counter=`LOCK_STABLE_CYCLES`-1: go to PERIPH and clear the counter.
- PERIPH:
  - Counter increments every edge.
  - On the edge where counter=`CPU_DELAY`-1: go to RUN.
  - `locked_s`=0 means restart.
- RUN: hold until a restart.
- Restart from PERIPH or RUN returns to WAIT_LOCK with the counter cleared. Priority when events coincide: lock loss (01) > button (10) > soft (11). `reset_cause` is written only on a restart.
- Restart events:
  - `locked_s` falling.
  - `btn_s` low.
  - `soft_reset_req`=1.
- Button held low keeps the FSM in WAIT_LOCK with the counter cleared. Sequencing resumes once it is released.
- `soft_reset_req` in WAIT_LOCK clears the counter; `reset_cause` is unchanged.
- Outputs are registered decodes of the next state, so they change on the transition edge:
  - `periph_resetn` = 1 in PERIPH and RUN.
  - `cpu_reset` = 0 in RUN only.
- Counter width is `$clog2(max(LOCK_STABLE_CYCLES, CPU_DELAY))`. The counter never wraps: it is compared for equality and cleared on every state change.

## Timing
- Reset values: `periph_resetn`=0, `cpu_reset`=1, `run`=0, `reset_cause`=00.
- Edge numbering: edge 1 is the first edge that samples `locked`=1. `periph_resetn` rises on edge `SYNC_STAGES`+`LOCK_STABLE_CYCLES`; `cpu_reset` falls `CPU_DELAY` edges after that.
- Input-to-reset latency:
  - Lock loss: both resets assert `SYNC_STAGES`+1 edges after `locked` is first sampled low.
  - Button: same figure, plus debounce when the macro is compiled in.
  - Soft request: both resets assert 1 edge after the pulse.
- A `locked` glitch shorter than one cycle may be missed. That is acceptable; the clock stage guarantees a level.

## Configuration
- `MFP_RESET_DEBOUNCE_EN` defined: `btn_s` changes only after the synchronized button has been stable for `DEBOUNCE_CYCLES` consecutive cycles. The debounce counter reset state is "released".
- Macro not defined: `btn_s` is the raw synchronizer output, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `mfp_reset_pkg`:
  - State enum, with encodings WAIT_LOCK=0, PERIPH=1, RUN=2.
  - Cause codes `RST_CAUSE_POR/LOCK/BTN/SOFT`.
- Sub-module `mfp_sync_ff`: parameterised `SYNC_STAGES` flop chain with a reset value. Instantiated for `locked` (reset 0) and `btn_resetn` (reset 1).

## Test plan
Bench parameters: `LOCK_STABLE_CYCLES`=8, `CPU_DELAY`=4, `SYNC_STAGES`=2.
- Power-up: `resetn`=0 for 3 cycles, then `locked`=1 -> `periph_resetn` rises at edge 10, `cpu_reset` falls at edge 14, `run`=1, `reset_cause`=00.
- Lock chatter: `locked` high 5 cycles, low 1, then high -> no release until 8 continuous `locked_s` cycles, counted from the re-rise.
- Lock loss in RUN -> both resets asserted 3 edges later, `reset_cause`=01, full sequence repeats.
- `soft_reset_req` pulse in RUN -> resets asserted next edge, `reset_cause`=11, `run` high again 12 edges later.
- Button and soft request on the same edge, with `locked` steady -> `reset_cause`=10; button held for 20 cycles keeps both resets asserted.
- `resetn` low mid-PERIPH -> next edge all outputs at reset values and `reset_cause`=00. With the macro, a 3-cycle button glitch and `DEBOUNCE_CYCLES`=16 -> no restart.
